sdcard_arbmod: RTL

- Two-client lock arbiter in front of sdcard_basemod.
- Grants exclusive ownership of the card command interface (call/addr/done/tag) and both FIFO ports to one requester at a time.
- Forwards the owner's commands as registered calls and routes done/tag back to the owner.
- Sits between application-level masters (e.g. a sector logger and a sector reader) and sdcard_basemod, inside the same top.

---
 rtl/sdcard_pkg.sv | 22 ++
 rtl/sdarb_rr2.sv | 25 ++
 rtl/sdcard_arbmod.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sdcard_pkg.sv
// Shared types and widths for the sdcard arbiter slice.
package sdcard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_BUSY = 2'd2,
    ST_HOLD = 2'd3
  } arb_state_e;

  localparam int unsigned CALL_W = 4;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned TAG_W  = 8;
  localparam int unsigned EN_W   = 2;

  localparam logic [TAG_W-1:0] TAG_TIMEOUT = 8'hFF;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdarb_rr2.sv
// Two-way round-robin picker: one-hot winner plus a pointer that moves past
// each client it grants.
module sdarb_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] win
);

  logic ptr_q, ptr_d;

  always_comb begin
    win   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) win = ptr_q ? 2'b10 : 2'b01;
    if (take && (req != 2'b00)) ptr_d = win[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sdcard_arbmod.sv
// Two-client lock arbiter in front of sdcard_basemod.
// Define SDARB_TIMEOUT_EN to enable the BUSY-state watchdog.
import sdcard_pkg::*;

module sdcard_arbmod #(
  parameter int unsigned TIMEOUT_CYC = 24'd10_000_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [1:0]        iReq,
  output logic [1:0]        oGnt,
  input  logic [CALL_W-1:0] iCall0,
  input  logic [CALL_W-1:0] iCall1,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [ADDR_W-1:0] iAddr1,
  output logic [1:0]        oDone,
  output logic [TAG_W-1:0]  oTag,
  input  logic [EN_W-1:0]   iEn0,
  input  logic [EN_W-1:0]   iEn1,
  input  logic [7:0]        iData0,
  input  logic [7:0]        iData1,
  output logic [7:0]        oData,
  output logic [CALL_W-1:0] oSdCall,
  input  logic              iSdDone,
  output logic [ADDR_W-1:0] oSdAddr,
  input  logic [TAG_W-1:0]  iSdTag,
  output logic [EN_W-1:0]   oSdEn,
  output logic [7:0]        oSdData,
  input  logic [7:0]        iSdData
);

  if ((CNT_W < 1) || (CNT_W > 31) || (TIMEOUT_CYC < 1) ||
      (TIMEOUT_CYC > (32'd1 << CNT_W))) begin : g_bad_cfg
    $error("sdcard_arbmod: TIMEOUT_CYC does not fit CNT_W");
  end

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CALL_W-1:0] sd_call_q, sd_call_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [1:0]        win;
  logic              req_own;
  logic [CALL_W-1:0] call_own;
  logic [ADDR_W-1:0] addr_own;

  sdarb_rr2 u_rr (
    .clk   (CLOCK),
    .rst_n (RESET),
    .req   (iReq),
    .take  (state_q == ST_IDLE),
    .win   (win)
  );

  assign req_own  = iReq[owner_q];
  assign call_own = owner_q ? iCall1 : iCall0;
  assign addr_own = owner_q ? iAddr1 : iAddr0;

`ifdef SDARB_TIMEOUT_EN
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             wd_expired;

  // Counter idles at zero outside BUSY, so entering BUSY always starts a fresh count.
  assign wd_d       = (state_q == ST_BUSY) ? wd_q + 1'b1 : '0;
  assign wd_expired = (wd_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    tag_d     = tag_q;
    sd_call_d = sd_call_q;
    sd_addr_d = sd_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iReq != 2'b00) begin
          gnt_d   = win;
          owner_d = win[1];
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        // Release wins over a call presented in the same cycle.
        if (!req_own) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end else if (call_own != '0) begin
          sd_call_d = call_own;
          sd_addr_d = addr_own;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (iSdDone) begin
          sd_call_d = '0;
          done_d    = onehot2(owner_q);
          tag_d     = iSdTag;
          state_d   = ST_HOLD;
        end
`ifdef SDARB_TIMEOUT_EN
        else if (wd_expired) begin
          sd_call_d = '0;
          done_d    = onehot2(owner_q);
          tag_d     = TAG_TIMEOUT;
          state_d   = ST_HOLD;
        end
`endif
      end
      ST_HOLD: state_d = ST_OWN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      tag_q     <= '0;
      sd_call_q <= '0;
      sd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      tag_q     <= tag_d;
      sd_call_q <= sd_call_d;
      sd_addr_q <= sd_addr_d;
    end
  end

  assign oGnt    = gnt_q;
  assign oDone   = done_q;
  assign oTag    = tag_q;
  assign oSdCall = sd_call_q;
  assign oSdAddr = sd_addr_q;
  assign oData   = iSdData;

  // FIFO enables/data pass through only for the current grant holder.
  always_comb begin
    oSdEn   = '0;
    oSdData = '0;
    if (gnt_q[0]) begin
      oSdEn   = iEn0;
      oSdData = iData0;
    end else if (gnt_q[1]) begin
      oSdEn   = iEn1;
      oSdData = iData1;
    end
  end

endmodule
